// File: rtl/sync_fifo_pkg.sv
// Shared helpers for sync_fifo: width arithmetic and parameter legality checks.
package sync_fifo_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

  // Pointers carry one extra wrap bit beyond the storage index.
  function automatic int ptr_width(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit thresh_legal(input int depth, input int afull, input int aempty);
    return (afull >= 1) && (afull <= depth) && (aempty >= 0) && (aempty <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo; slave is the FIFO side.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int CW = ptr_width(DEPTH);

  logic                  io_flush;
  logic                  io_enq_valid;
  logic                  io_enq_ready;
  logic [DATA_WIDTH-1:0] io_enq_data;
  logic                  io_deq_valid;
  logic                  io_deq_ready;
  logic [DATA_WIDTH-1:0] io_deq_data;
  logic [CW-1:0]         io_count;
  logic                  io_almost_full;
  logic                  io_almost_empty;

  modport master (
    output io_flush, io_enq_valid, io_enq_data, io_deq_ready,
    input  io_enq_ready, io_deq_valid, io_deq_data, io_count,
           io_almost_full, io_almost_empty
  );

  modport slave (
    input  io_flush, io_enq_valid, io_enq_data, io_deq_ready,
    output io_enq_ready, io_deq_valid, io_deq_data, io_count,
           io_almost_full, io_almost_empty
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous read port.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int AW        = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; only the pointers define which words are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Parametrised single-clock FIFO with valid/ready on both sides, flush and level flags.
// Optional zero-latency pass-through when empty: define SYNC_FIFO_BYPASS_EN.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic      clk,
  input  logic      reset,
  sync_fifo_if.slave io
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] AFULL_LVL  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_LVL = PW'(AEMPTY_THRESH);

  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("sync_fifo: DATA_WIDTH must be at least 1");
  end
  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two, at least 2");
  end
  if (!thresh_legal(DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_thresh
    $error("sync_fifo: AFULL_THRESH or AEMPTY_THRESH out of range");
  end

  logic [PW-1:0]         wp;
  logic [PW-1:0]         rp;
  logic [PW-1:0]         count;
  logic                  empty;
  logic                  full;
  logic                  enq;
  logic                  deq;
  logic                  clear;
  logic [DATA_WIDTH-1:0] rd_data;

  assign empty = (wp == rp);
  assign full  = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
  assign count = wp - rp;
  assign clear = reset | io.io_flush;

  // Ready never looks at the consumer, so a full FIFO refuses data even while draining.
  assign io.io_enq_ready = ~full;
  assign deq             = ~empty & io.io_deq_ready;

`ifdef SYNC_FIFO_BYPASS_EN
  logic bypass;

  // A word that passes straight through an empty FIFO never touches storage.
  assign bypass         = empty & io.io_enq_valid & io.io_deq_ready;
  assign enq            = io.io_enq_valid & ~full & ~bypass;
  assign io.io_deq_valid = empty ? io.io_enq_valid : 1'b1;
  assign io.io_deq_data  = empty ? io.io_enq_data  : rd_data;
`else
  assign enq            = io.io_enq_valid & ~full;
  assign io.io_deq_valid = ~empty;
  assign io.io_deq_data  = rd_data;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clear) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (enq) wp <= wp + PW'(1);
      if (deq) rp <= rp + PW'(1);
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk    (clk),
    .wr_en  (enq & ~clear),
    .wr_addr(wp[AW-1:0]),
    .wr_data(io.io_enq_data),
    .rd_addr(rp[AW-1:0]),
    .rd_data(rd_data)
  );

  assign io.io_count        = count;
  assign io.io_almost_full  = (count >= AFULL_LVL);
  assign io.io_almost_empty = (count <= AEMPTY_LVL);

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (DEPTH=16, DATA_WIDTH=8, thresholds 14/2); covers both bypass builds.
module tb_sync_fifo;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  sync_fifo_if #(.DATA_WIDTH(8), .DEPTH(16)) bus ();

  sync_fifo #(
    .DATA_WIDTH   (8),
    .DEPTH        (16),
    .AFULL_THRESH (14),
    .AEMPTY_THRESH(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .io   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       flush;
    logic       enq_valid;
    logic [7:0] enq_data;
    logic       deq_ready;
    logic [4:0] count;
    logic       deq_valid;
    logic [7:0] deq_data;
    logic       af;
    logic       ae;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    bus.io_flush     = 1'b0;
    bus.io_enq_valid = 1'b0;
    bus.io_enq_data  = 8'h00;
    bus.io_deq_ready = 1'b0;
  endtask

  // Drive one cycle of inputs, clock it in, then return to idle so outputs reflect state only.
  task automatic step(input logic fl, input logic ev, input logic [7:0] ed, input logic dr);
    bus.io_flush     = fl;
    bus.io_enq_valid = ev;
    bus.io_enq_data  = ed;
    bus.io_deq_ready = dr;
    @(posedge clk);
    #1;
    set_idle();
    #1;
  endtask

  task automatic check_level(input string tag, input int cnt);
    check({tag, "_count"},     32'(bus.io_count),        32'(cnt));
    check({tag, "_enq_ready"}, 32'(bus.io_enq_ready),    32'(cnt < 16));
    check({tag, "_deq_valid"}, 32'(bus.io_deq_valid),    32'(cnt != 0));
    check({tag, "_afull"},     32'(bus.io_almost_full),  32'(cnt >= 14));
    check({tag, "_aempty"},    32'(bus.io_almost_empty), 32'(cnt <= 2));
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;

    check_level("reset", 0);

    //            fl  ev  data   dr  cnt dv  head   af  ae
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 8'h11, 1'b0, 5'd1, 1'b1, 8'h11, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 8'h22, 1'b0, 5'd2, 1'b1, 8'h11, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 8'h33, 1'b0, 5'd3, 1'b1, 8'h11, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'h44, 1'b1, 5'd3, 1'b1, 8'h22, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd2, 1'b1, 8'h33, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd1, 1'b1, 8'h44, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 8'h55, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 8'h66, 1'b0, 5'd1, 1'b1, 8'h66, 1'b0, 1'b1};

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].flush, vecs[i].enq_valid, vecs[i].enq_data, vecs[i].deq_ready);
      check($sformatf("vec%0d_count", i),  32'(bus.io_count),        32'(vecs[i].count));
      check($sformatf("vec%0d_dvalid", i), 32'(bus.io_deq_valid),    32'(vecs[i].deq_valid));
      check($sformatf("vec%0d_eready", i), 32'(bus.io_enq_ready),    32'(vecs[i].count != 5'd16));
      check($sformatf("vec%0d_afull", i),  32'(bus.io_almost_full),  32'(vecs[i].af));
      check($sformatf("vec%0d_aempty", i), 32'(bus.io_almost_empty), 32'(vecs[i].ae));
      if (vecs[i].deq_valid)
        check($sformatf("vec%0d_data", i), 32'(bus.io_deq_data), 32'(vecs[i].deq_data));
    end

    // Fill to full, then offer a 17th word that must be refused.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0);
      check_level($sformatf("fill%0d", i), i + 1);
      check($sformatf("fill%0d_head", i), 32'(bus.io_deq_data), 32'h00);
    end
    step(1'b0, 1'b1, 8'hEE, 1'b0);
    check_level("overfill", 16);

    // Drain in order.
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d_data", i), 32'(bus.io_deq_data), 32'(i));
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check_level($sformatf("drain%0d", i), 15 - i);
    end

    // Full with both sides active: only the dequeue happens.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
    check_level("full_pre", 16);
    step(1'b0, 1'b1, 8'hEE, 1'b1);
    check_level("full_both", 15);
    check("full_both_head", 32'(bus.io_deq_data), 32'h81);

    // Half full, streaming through 40 cycles of pointer wrap.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
    for (int k = 0; k < 40; k++) begin
      check($sformatf("wrap%0d_head", k), 32'(bus.io_deq_data), 32'(8'(k)));
      step(1'b0, 1'b1, 8'(k + 8), 1'b1);
      check($sformatf("wrap%0d_count", k), 32'(bus.io_count), 32'd8);
    end
    check("wrap_end_head", 32'(bus.io_deq_data), 32'd40);

    // Flush together with an enqueue: the word is lost.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
    check_level("preflush", 5);
    step(1'b1, 1'b1, 8'h77, 1'b0);
    check_level("flush", 0);
    step(1'b0, 1'b1, 8'h99, 1'b0);
    check_level("postflush", 1);
    check("postflush_head", 32'(bus.io_deq_data), 32'h99);

    // Empty FIFO offered a word with the consumer ready.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    bus.io_enq_valid = 1'b1;
    bus.io_enq_data  = 8'hA5;
    bus.io_deq_ready = 1'b1;
    #1;
`ifdef SYNC_FIFO_BYPASS_EN
    check("bypass_dvalid", 32'(bus.io_deq_valid), 32'd1);
    check("bypass_data",   32'(bus.io_deq_data),  32'hA5);
    check("bypass_count",  32'(bus.io_count),     32'd0);
    @(posedge clk);
    #1;
    set_idle();
    #1;
    check_level("bypass_after", 0);
`else
    check("nobypass_dvalid", 32'(bus.io_deq_valid), 32'd0);
    check("nobypass_count",  32'(bus.io_count),     32'd0);
    @(posedge clk);
    #1;
    set_idle();
    #1;
    check_level("nobypass_after", 1);
    check("nobypass_data", 32'(bus.io_deq_data), 32'hA5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
